// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register busy
// scoreboard and a post-reset clearing sweep.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
// rstn is an asynchronous, active-high reset.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                in_run;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    busy_nxt;

    logic [ADDR_W-1:0]   wa [NUM_WR];
    logic [DATA_W-1:0]   wd [NUM_WR];
    logic [NUM_WR-1:0]   wr_ok;
    logic [ADDR_W-1:0]   ra [NUM_RD];

    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
    logic [NUM_RD-1:0]        rd_busy_nxt;

    // State register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= ST_INIT;
        else      state <= state_nxt;
    end

    // Next state: sweep every register once, then run until the next reset
    always_comb begin
        state_nxt = state;
        in_run    = 1'b0;
        case (state)
            ST_INIT: begin
                if (sweep_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                in_run = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Sweep counter advances one register per INIT cycle
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)                  sweep_cnt <= '0;
        else if (state == ST_INIT) sweep_cnt <= sweep_cnt + ADDR_W'(1);
    end

    // ready rises on the edge that writes the last register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) ready <= 1'b0;
        else      ready <= (state_nxt == ST_RUN);
    end

    // Unpack ports and qualify writes (INIT ignores them, r0 may be hardwired)
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wa[j]    = wr_addr[j*ADDR_W +: ADDR_W];
            wd[j]    = wr_data[j*DATA_W +: DATA_W];
            wr_ok[j] = in_run && wr_en[j] && !(ZR && (wa[j] == '0));
        end
        for (int i = 0; i < NUM_RD; i++) begin
            ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Storage: zero-fill during the sweep, else ascending ports so highest j wins
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[sweep_cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) mem[wa[j]] <= wd[j];
            end
        end
    end

    // Scoreboard update: write-back clears, reservation sets and wins
    always_comb begin
        busy_nxt = busy;
        if (in_run) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) busy_nxt[wa[j]] = 1'b0;
            end
            if (rsv_en && !(ZR && (rsv_addr == '0))) busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) busy <= '0;
        else      busy <= busy_nxt;
    end

    // Read path: old contents, or same-cycle write data when bypass is built in
    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_nxt[i*DATA_W +: DATA_W] = mem[ra[i]];
            rd_busy_nxt[i]                  = busy_nxt[ra[i]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j] && (wa[j] == ra[i])) rd_data_nxt[i*DATA_W +: DATA_W] = wd[j];
            end
`else
            rd_data_nxt[i*DATA_W +: DATA_W] = mem[ra[i]];
            rd_busy_nxt[i]                  = busy[ra[i]];
`endif
            if (!in_run || (ZR && (ra[i] == '0))) begin
                rd_data_nxt[i*DATA_W +: DATA_W] = '0;
                rd_busy_nxt[i]                  = 1'b0;
            end
        end
    end

    // Registered read outputs
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            rd_data <= rd_data_nxt;
            rd_busy <= rd_busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp; drives an integer-file
// instance (ZERO_REG=1) and a float-file instance (ZERO_REG=0) in parallel.
module tb_regfile_mp;

    logic        clk;
    logic        rstn;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic        ready_i, ready_f;
    logic [63:0] rd_data_i, rd_data_f;
    logic [1:0]  rd_busy_i, rd_busy_f;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(.ZERO_REG(1)) dut_i (
        .clk(clk), .rstn(rstn), .ready(ready_i),
        .rd_addr(rd_addr), .rd_data(rd_data_i), .rd_busy(rd_busy_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    regfile_mp #(.ZERO_REG(0)) dut_f (
        .clk(clk), .rstn(rstn), .ready(ready_f),
        .rd_addr(rd_addr), .rd_data(rd_data_f), .rd_busy(rd_busy_f),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One rising edge; return at the falling edge where outputs are stable
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    // Count cycles with ready low after reset release, bounded
    task automatic sweep_len(input string tag);
        int n;
        n = 0;
        while (!ready_i && n < 100) begin
            n++;
            tick();
        end
        check(tag, 64'(n), 64'd32);
        check({tag, "_f"}, 64'(ready_f), 64'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [31:0] exp_byp;
        rstn = 1'b1;
        idle();
        set_rd(5'd0, 5'd0);
        repeat (3) tick();

        check("rst_ready", 64'(ready_i), 64'd0);
        check("rst_rd_data", rd_data_i, 64'd0);
        check("rst_rd_busy", 64'(rd_busy_i), 64'd0);

        // Writes and reservations during the sweep must be ignored
        set_wr(2'b01, 5'd4, 32'hFFFF_FFFF, 5'd0, 32'd0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        set_rd(5'd4, 5'd4);
        rstn = 1'b0;
        check("init_rd_data", rd_data_i, 64'd0);
        sweep_len("init_len");
        idle();

        // Every register reads zero after the sweep
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            tick();
            check("sweep_p0", {32'd0, rd_data_i[31:0]}, 64'd0);
            check("sweep_p1", {32'd0, rd_data_i[63:32]}, 64'd0);
            check("sweep_f", {32'd0, rd_data_f[31:0]}, 64'd0);
        end
        set_rd(5'd4, 5'd4);
        tick();
        check("init_rsv_ign", 64'(rd_busy_i), 64'd0);

        // Single write, dual-port read
        set_wr(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
        tick();
        idle();
        set_rd(5'd5, 5'd5);
        tick();
        check("r5_p0", {32'd0, rd_data_i[31:0]}, 64'hDEAD_BEEF);
        check("r5_p1", {32'd0, rd_data_i[63:32]}, 64'hDEAD_BEEF);

        // Same-address write collision: highest port wins
        set_wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        tick();
        idle();
        set_rd(5'd7, 5'd5);
        tick();
        check("r7_collide", {32'd0, rd_data_i[31:0]}, 64'h22);
        check("r5_indep", {32'd0, rd_data_i[63:32]}, 64'hDEAD_BEEF);

        // Register 0: hardwired in the integer file, ordinary in the float file
        set_wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'd0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        tick();
        check("r0_zr_data", {32'd0, rd_data_i[31:0]}, 64'd0);
        check("r0_zr_busy", 64'(rd_busy_i[0]), 64'd0);
        check("r0_f_data", {32'd0, rd_data_f[31:0]}, 64'h1234);
        check("r0_f_busy", 64'(rd_busy_f[0]), 64'd1);

        // Scoreboard: reserve, reserve+write-back, write-back alone
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        tick();
        idle();
        set_rd(5'd9, 5'd9);
        tick();
        check("r9_rsv", 64'(rd_busy_i), 64'd3);

        set_wr(2'b10, 5'd0, 32'd0, 5'd9, 32'h99);
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        tick();
        idle();
        tick();
        check("r9_rsv_wins", 64'(rd_busy_i[0]), 64'd1);
        check("r9_data1", {32'd0, rd_data_i[31:0]}, 64'h99);

        set_wr(2'b01, 5'd9, 32'h77, 5'd0, 32'd0);
        tick();
        idle();
        tick();
        check("r9_wb_clr", 64'(rd_busy_i[0]), 64'd0);
        check("r9_data2", {32'd0, rd_data_i[31:0]}, 64'h77);

        // Same-cycle write and read of r3 (old value 0)
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hCAFE;
`else
        exp_byp = 32'h0;
`endif
        set_wr(2'b01, 5'd3, 32'hCAFE, 5'd0, 32'd0);
        set_rd(5'd3, 5'd3);
        tick();
        idle();
        check("r3_same_cyc", {32'd0, rd_data_i[31:0]}, {32'd0, exp_byp});
        tick();
        check("r3_after", {32'd0, rd_data_i[31:0]}, 64'hCAFE);

        // Register 0 rule overrides bypass; float file follows the build option
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h1234;
`endif
        set_wr(2'b01, 5'd0, 32'h55, 5'd0, 32'd0);
        set_rd(5'd0, 5'd0);
        tick();
        idle();
        check("r0_zr_byp", {32'd0, rd_data_i[31:0]}, 64'd0);
        check("r0_f_byp", {32'd0, rd_data_f[31:0]}, {32'd0, exp_byp});

        // Reset in RUN, then again mid-sweep at counter 10: sweep restarts from 0
        rstn = 1'b1;
        tick();
        check("rerst_ready", 64'(ready_i), 64'd0);
        check("rerst_data", rd_data_i, 64'd0);
        rstn = 1'b0;
        repeat (10) tick();
        check("mid_ready", 64'(ready_i), 64'd0);
        rstn = 1'b1;
        tick();
        check("mid_rst_ready", 64'(ready_i), 64'd0);
        rstn = 1'b0;
        sweep_len("resweep_len");

        set_rd(5'd5, 5'd7);
        tick();
        check("resweep_r5", {32'd0, rd_data_i[31:0]}, 64'd0);
        check("resweep_r7", {32'd0, rd_data_i[63:32]}, 64'd0);
        check("resweep_busy", 64'(rd_busy_f), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the core's 2-read/1-write integer register file.
- Configurable read/write port count, data width and depth; optional hardwired zero register, so one block serves the integer and float files.
- Adds a per-register busy scoreboard for issue-stage hazard checks and a post-reset clearing sweep.
- Sits between decode (read ports, reservations) and write-back (write ports).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, read port count (3 for the FMA float file)
- NUM_WR, 2, write port count
- ZERO_REG, 1, 1 = register 0 hardwired to zero (integer file); 0 = register 0 is ordinary (float file)

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-high (asserted = 1)
- ready  out  1  1 once the clearing sweep is done
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, same packing
- rd_busy  out  NUM_RD  registered busy flag of each read address
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve (mark busy) a destination register
- rsv_addr  in  ADDR_W  register to reserve

Behaviour:
- Reset (asynchronous assert): rd_data=0, rd_busy=0, ready=0, all busy bits=0, sweep counter=0, state=INIT. Register contents are not reset directly.
- FSM INIT: one register written with 0 per cycle, counter 0..DEPTH-1.
  - After writing DEPTH-1, go to RUN; ready=1 from the next cycle. INIT lasts exactly DEPTH cycles after reset deasserts.
  - In INIT, wr_en and rsv_en are ignored; rd_data and rd_busy are driven 0.
- FSM RUN: stays in RUN until the next reset. Reset asserted mid-sweep or in RUN returns to INIT with counter 0.
- Read: 1-cycle latency. rd_data[i] and rd_busy[i] on edge t+1 reflect rd_addr[i] sampled at edge t.
- Ports are independent; any number may read the same address.
- Write: wr_en[j] writes wr_data[j] to wr_addr[j] at the edge. If several ports hit the same address, the highest index j wins.
- Write-back clears busy[wr_addr[j]] for every enabled port j.
- Reserve: rsv_en sets busy[rsv_addr]. Reserve and write-back to the same register in the same cycle leaves busy=1 (reservation wins).
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - reads of address 0 return 0 with rd_busy=0;
  - reservations of address 0 are ignored.
- ZERO_REG=0: address 0 behaves like every other register.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches an enabled write in the same cycle returns that write data (highest matching j). rd_busy reflects the post-edge busy value, i.e. 0 unless the same register is also reserved that cycle.
- Undefined: read-before-write. A same-cycle read returns the old contents and the pre-edge busy bit, as in the previous-generation file.
- The ZERO_REG rule overrides bypass in both builds.

Test Plan:
- Reset release, default params -> ready=0 for 32 cycles, 1 on cycle 33; read all 32 registers -> every rd_data=0.
- RUN: write 0xDEADBEEF to r5 via port 0; next cycle read r5 on ports 0 and 1 -> both return 0xDEADBEEF one cycle after address presented.
- Ports 0 and 1 both write r7 (0x11, 0x22) in the same cycle -> r7 reads 0x22.
- ZERO_REG=1: write 0x1234 to r0, reserve r0 -> r0 reads 0, rd_busy=0. ZERO_REG=0: same sequence -> r0 reads 0x1234, busy=1.
- Reserve r9 -> rd_busy=1. Write-back r9 while re-reserving r9 -> busy stays 1. Write-back alone -> busy=0.
- Write r3=0xCAFE while reading r3, old value 0: with REGFILE_BYPASS_EN -> 0xCAFE; without -> 0. Assert rstn at sweep counter 10 -> ready stays 0 and the sweep restarts from 0.
